// File: rtl/ddr5_cmd_responder.sv
// ddr5_cmd_responder: simplified DDR5 device model that decodes CS_n/CA commands, tracks 16 banks, stores write bursts and returns read bursts
// Ports: clk, rst (async, active-high); cs_n/ca/cai command bus; dm_n/dq_in write data;
//        dq_out/dq_oe/dqs_t/dqs_c read data and strobes; alert_n one-cycle-low error flag.
// Optional: define DDR5_RSP_PARTIAL_WRITE_EN to honour wrp_bar/dm_n beat masking on writes.
module ddr5_cmd_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int RL = 11,
  parameter int WL = 8,
  parameter int BURST_LEN = 16,
  parameter int ROW_KEEP = 2,
  parameter int COL_KEEP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic [13:0]           ca,
  input  logic                  cai,
  input  logic [2:0]            dm_n,
  input  logic [DATA_WIDTH-1:0] dq_in,
  output logic [DATA_WIDTH-1:0] dq_out,
  output logic                  dq_oe,
  output logic                  dqs_t,
  output logic                  dqs_c,
  output logic                  alert_n
);
  localparam int BW = $clog2(BURST_LEN);
  localparam int AW = 4 + ROW_KEEP + COL_KEEP + BW;
  localparam int BASEW = AW - BW;
  typedef enum logic {CMD_IDLE, CMD_P2} cmd_t;
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_READ, D_WRITE} dat_t;
  typedef enum logic [1:0] {OP_ACT, OP_RD, OP_WR} op_t;
  cmd_t cmd_state, cmd_next;
  dat_t d_state, d_next;
  op_t p_op;
  logic [13:0] cae;
  logic is_act, is_rd, is_wr, is_pre, p2, last, in_burst, ap_close, p_open, start, err, wr_keep, we;
  logic [3:0] p_bidx;
  logic [ROW_KEEP-1:0] p_row;
  logic [15:0] bank_open;
  logic [ROW_KEEP-1:0] bank_row [16];
  logic [7:0] cnt;
  logic [BW-1:0] beat;
  logic [BASEW-1:0] d_base;
  logic d_rd, d_ap, d_wrp;
  logic [AW-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] mem [2**AW];
  logic unused;
  assign cae = cai ? ~ca : ca;
  assign is_act = cae[1:0] == 2'b00;
  assign is_rd = cae[4:0] == 5'b11101;
  assign is_wr = cae[4:0] == 5'b01101;
  assign is_pre = cae[5:0] == 6'b011011;
  assign p2 = cmd_state == CMD_P2 && cs_n;
  assign last = beat == BW'(BURST_LEN - 1);
  assign in_burst = d_state == D_READ || d_state == D_WRITE;
  assign ap_close = in_burst && last && d_ap;
  // A bank auto-precharging this cycle already counts as closed, so an ACT landing now reopens it.
  assign p_open = bank_open[p_bidx] && !(ap_close && d_base[BASEW-1 -: 4] == p_bidx);
  assign start = p2 && p_op != OP_ACT && p_open && d_state == D_IDLE;
  assign err = (!cs_n && !(is_act || is_rd || is_wr || is_pre)) || (cmd_state == CMD_P2 && !cs_n) ||
               (p2 && (p_op == OP_ACT ? p_open : (!p_open || d_state != D_IDLE)));
  // Read data is registered, so the address runs one beat ahead of what is on the bus.
  assign rd_idx = {d_base, d_state == D_WAIT ? BW'(0) : beat + BW'(1)};
`ifdef DDR5_RSP_PARTIAL_WRITE_EN
  assign wr_keep = !(d_wrp && dm_n != 3'b111);
`else
  assign wr_keep = 1'b1;
`endif
  assign we = d_state == D_WRITE && wr_keep;
  assign unused = ^{cae, dm_n, d_wrp};
  always_comb begin
    cmd_next = (!cs_n && (is_act || is_rd || is_wr)) ? CMD_P2 : CMD_IDLE;
    d_next = d_state == D_IDLE ? (start ? D_WAIT : D_IDLE) :
             d_state == D_WAIT ? (cnt <= 8'd1 ? (d_rd ? D_READ : D_WRITE) : D_WAIT) :
             last ? D_IDLE : d_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmd_state <= CMD_IDLE;
      d_state <= D_IDLE;
    end else begin
      cmd_state <= cmd_next;
      d_state <= d_next;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alert_n <= 1'b1;
      bank_open <= '0;
      for (int i = 0; i < 16; i++) bank_row[i] <= '0;
      p_op <= OP_ACT;
      p_bidx <= '0;
      p_row <= '0;
      cnt <= '0;
      beat <= '0;
      d_base <= '0;
      d_rd <= 1'b0;
      d_ap <= 1'b0;
      d_wrp <= 1'b0;
      dq_out <= '0;
      dq_oe <= 1'b0;
      dqs_t <= 1'b0;
      dqs_c <= 1'b1;
    end else begin
      alert_n <= !err;
      if (!cs_n) begin
        p_op <= is_rd ? OP_RD : (is_wr ? OP_WR : OP_ACT);
        p_bidx <= cae[10:7];
        p_row <= cae[2 +: ROW_KEEP];
      end
      if (ap_close) bank_open[d_base[BASEW-1 -: 4]] <= 1'b0;
      if (!cs_n && is_pre) bank_open[cae[10:7]] <= 1'b0;
      if (p2 && p_op == OP_ACT && !p_open) begin
        bank_open[p_bidx] <= 1'b1;
        bank_row[p_bidx] <= p_row;
      end
      if (start) begin
        d_rd <= p_op == OP_RD;
        d_ap <= !cae[10];
        d_wrp <= !cae[11];
        d_base <= {p_bidx, bank_row[p_bidx], cae[3 +: COL_KEEP]};
        cnt <= p_op == OP_RD ? 8'(RL - 1) : 8'(WL - 1);
      end else if (d_state == D_WAIT) cnt <= cnt - 1'b1;
      beat <= in_burst ? beat + 1'b1 : '0;
      if (d_state == D_WAIT && cnt <= 8'd1 && d_rd) begin
        dq_out <= mem[rd_idx];
        dq_oe <= 1'b1;
        dqs_t <= 1'b1;
        dqs_c <= 1'b0;
      end else if (d_state == D_READ) begin
        if (last) begin
          dq_oe <= 1'b0;
          dqs_t <= 1'b0;
          dqs_c <= 1'b1;
        end else begin
          dq_out <= mem[rd_idx];
          dqs_t <= ~dqs_t;
          dqs_c <= dqs_t;
        end
      end
    end
  always_ff @(posedge clk)
    if (we) mem[{d_base, beat}] <= dq_in;
endmodule
